alu_op_issuer: RTL and testbench
================================

# alu_op_issuer

RTL initiator that drives the ALU's operand/command interface and collects its result, turning a host valid/ready request stream into correctly sequenced ALU transactions. It sits between a command source (CPU-side register block or test sequencer) and the ALU: it owns `opa/opb/ce/mode/cin/inp_valid/cmd` and consumes `res/oflow/cout/g/l/e/err`. It returns one tagged response per request, with the ALU result and flags.

## Interface
- `WIDTH`, default `` `WIDTH `` (8): operand width. `res` is `WIDTH+1`.
- `CMD_WIDTH`, default `` `CMD_WIDTH `` (4): ALU command width.
- `RES_LAT`, default 1: cycles from the final operand beat to the cycle in which ALU outputs are valid. Must be ≥1.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_opa`, `req_opb` in WIDTH: operands.
- `req_cmd` in CMD_WIDTH; `req_mode` in 1; `req_cin` in 1: ALU command fields.
- `req_split` in 1: 1 delivers the operands in two beats (A, then B); 0 delivers them in one beat.
- `opa`, `opb` out WIDTH; `cmd` out CMD_WIDTH; `mode`, `cin`, `ce` out 1; `inp_valid` out 2: ALU drive.
- `res` in WIDTH+1; `oflow`, `cout`, `g`, `l`, `e`, `err` in 1: ALU result.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_res` out WIDTH+1: captured ALU result.
- `rsp_flags` out 5: `{oflow,cout,g,l,e}`.
- `rsp_err` out 1: captured `err`.

## Operation
- The FSM has the states IDLE, ISSUE, BEAT_A, BEAT_B, WAIT and RESP.
- **IDLE:** `req_ready=1`, `ce=0`, `inp_valid=00`. When `req_valid` is high, the request is latched. The FSM then moves to BEAT_A if `req_split=1`, otherwise to ISSUE.
- **ISSUE:** drives `ce=1`, `inp_valid=11`, both operands, `cmd`, `mode` and `cin`. Next state is WAIT.
- **BEAT_A:** drives `ce=1`, `inp_valid=01`, `opa` valid and `opb=0`, plus `cmd`/`mode`/`cin`. Next state is BEAT_B.
- **BEAT_B:** drives `ce=1`, `inp_valid=10`, `opb` valid. `opa` is held at its latched value. Next state is WAIT.
- **WAIT:** `ce=1`, `inp_valid=00`, command fields held.
  - A down-counter is loaded with `RES_LAT-1` on entry.
  - When the counter is 0, `res` and the flags are sampled into the response register and the FSM moves to RESP.
- **RESP:** `rsp_valid=1`, `ce=0`, `inp_valid=00`. The response stays stable until `rsp_ready=1`, then the FSM returns to IDLE.
- `req_ready` is high only in IDLE. The block holds at most one request in flight.
- Outputs to the ALU are registered. They change only on `clk` edges.

## Timing
- **Reset:** when `rst=0` at a rising edge, the FSM goes to IDLE and the following outputs are cleared next cycle:
  - `opa`, `opb`, `cmd`, `mode`, `cin`, `ce`, `inp_valid` → 0.
  - `rsp_valid`, `rsp_res`, `rsp_flags`, `rsp_err` → 0.
  - `req_ready` → 1.
- **Reset mid-operation** (any state): the transaction is dropped and no response is produced. `ce` and `inp_valid` are 0 in the next cycle.
- **Non-split latency:** with the request accepted at the edge ending cycle 0, ISSUE is cycle 1, WAIT is cycles 2..RES_LAT+1, and `rsp_valid` rises in cycle RES_LAT+2. Split requests take one extra cycle.
- **Sampling point:** `res` is sampled at the edge ending cycle T+RES_LAT, where T is the final operand beat.
- **Throughput:** one operation per RES_LAT+3 cycles (non-split) when `rsp_ready` is held at 1.
- **RESP with `rsp_ready=1` and `req_valid=1`:** the response completes. The new request is not accepted until the following cycle (IDLE).
- **`rsp_ready` held at 0:** the FSM stays in RESP indefinitely. The ALU is not driven (`ce=0`).
- **Counter:** width is `$clog2(RES_LAT+1)`. It does not wrap because it is reloaded on every WAIT entry.

## Structure
- `alu_issuer_pkg` contains:
  - the state enum `issuer_state_e`;
  - flag index constants `FLG_OFLOW=4, FLG_COUT=3, FLG_G=2, FLG_L=1, FLG_E=0`;
  - `inp_valid` encodings `IV_NONE=2'b00, IV_A=2'b01, IV_B=2'b10, IV_AB=2'b11`.
- `WIDTH`/`CMD_WIDTH` defaults come from `alu_define.svh`.
- One natural sub-module, `alu_rsp_buf`: a single-entry valid/ready response holding register with a capture strobe.

## Test plan
- **Reset:** hold `rst=0` for 3 cycles with `req_valid=1`. Required: `req_ready=1`, `ce=0`, `inp_valid=00`, `rsp_valid=0`, and no request accepted.
- **Non-split ADD:** `opa=8'h0F`, `opb=8'h01`, `cmd=0`, `mode=1`, `RES_LAT=1`. Required:
  - cycle 1: `inp_valid=11`, `opa=0F`, `opb=01`;
  - cycle 3: `rsp_valid=1`, `rsp_res=9'h010`, `rsp_flags[FLG_COUT]=0`.
- **Split request:** `opa=8'hFF`, `opb=8'h01`, ADD. Required:
  - cycle 1: `inp_valid=01`, `opb=0`;
  - cycle 2: `inp_valid=10`, `opb=01`;
  - cycle 4: `rsp_res=9'h100`, `cout` flag set.
- **Backpressure:** hold `rsp_ready=0` for 5 cycles after `rsp_valid`. Required: `rsp_*` stable, `req_ready=0`, `ce=0`. Release `rsp_ready`: IDLE in the next cycle.
- **Reset during WAIT:** drive `rst=0` in the WAIT cycle. Required: no `rsp_valid` afterwards, and the next request completes normally.
- **`RES_LAT=3`:** compare (`opa=5`, `opb=5`) against an ALU model. Required: `rsp_valid` in cycle 5 and `rsp_flags[FLG_E]=1`.

Source files
------------

// File: rtl/alu_issuer_pkg.sv
// Shared state, flag-index and inp_valid encodings for the ALU operation issuer.
// Operand and command width defaults are set here so every file sees the same values.
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef CMD_WIDTH
`define CMD_WIDTH 4
`endif

package alu_issuer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      BEAT_A,
      BEAT_B,
      WAIT,
      RESP
   } issuer_state_e;

   localparam int FLG_OFLOW = 4;
   localparam int FLG_COUT  = 3;
   localparam int FLG_G     = 2;
   localparam int FLG_L     = 1;
   localparam int FLG_E     = 0;
   localparam int FLG_W     = 5;

   localparam logic [1:0] IV_NONE = 2'b00;
   localparam logic [1:0] IV_A    = 2'b01;
   localparam logic [1:0] IV_B    = 2'b10;
   localparam logic [1:0] IV_AB   = 2'b11;

endpackage

// File: rtl/alu_rsp_buf.sv
// Single-entry response holding register: loads on a capture strobe and
// stays valid and stable until the consumer accepts it.
module alu_rsp_buf
   import alu_issuer_pkg::*;
#(
   parameter int RES_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_cap,
   input  logic [RES_W-1:0] i_res,
   input  logic [FLG_W-1:0] i_flags,
   input  logic             i_err,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [RES_W-1:0] o_res,
   output logic [FLG_W-1:0] o_flags,
   output logic             o_err
);

   logic             r_valid;
   logic [RES_W-1:0] r_res;
   logic [FLG_W-1:0] r_flags;
   logic             r_err;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_res   <= '0;
         r_flags <= '0;
         r_err   <= 1'b0;
      end else if (i_cap) begin
         r_valid <= 1'b1;
         r_res   <= i_res;
         r_flags <= i_flags;
         r_err   <= i_err;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_res   = r_res;
   assign o_flags = r_flags;
   assign o_err   = r_err;

endmodule

// File: rtl/alu_op_issuer.sv
// Turns a valid/ready request stream into sequenced ALU operand/command beats
// and returns one response per request carrying the sampled ALU result and flags.
module alu_op_issuer
   import alu_issuer_pkg::*;
#(
   parameter int WIDTH     = `WIDTH,
   parameter int CMD_WIDTH = `CMD_WIDTH,
   parameter int RES_LAT   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [WIDTH-1:0]     req_opa,
   input  logic [WIDTH-1:0]     req_opb,
   input  logic [CMD_WIDTH-1:0] req_cmd,
   input  logic                 req_mode,
   input  logic                 req_cin,
   input  logic                 req_split,
   output logic [WIDTH-1:0]     opa,
   output logic [WIDTH-1:0]     opb,
   output logic [CMD_WIDTH-1:0] cmd,
   output logic                 mode,
   output logic                 cin,
   output logic                 ce,
   output logic [1:0]           inp_valid,
   input  logic [WIDTH:0]       res,
   input  logic                 oflow,
   input  logic                 cout,
   input  logic                 g,
   input  logic                 l,
   input  logic                 e,
   input  logic                 err,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WIDTH:0]       rsp_res,
   output logic [FLG_W-1:0]     rsp_flags,
   output logic                 rsp_err
);

   localparam int             CNT_W    = $clog2(RES_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RES_LAT - 1);

   issuer_state_e        r_state;
   logic [WIDTH-1:0]     r_opa;
   logic [WIDTH-1:0]     r_opb;
   logic [WIDTH-1:0]     r_opb_lat;
   logic [CMD_WIDTH-1:0] r_cmd;
   logic                 r_mode;
   logic                 r_cin;
   logic                 r_ce;
   logic [1:0]           r_iv;
   logic                 r_req_ready;
   logic [CNT_W-1:0]     r_cnt;

   logic                 w_cap;
   logic [FLG_W-1:0]     w_flags;

   // Outputs are loaded on the edge that enters each state, so the ALU sees
   // them for exactly the cycle the FSM spends there.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_opa       <= '0;
         r_opb       <= '0;
         r_opb_lat   <= '0;
         r_cmd       <= '0;
         r_mode      <= 1'b0;
         r_cin       <= 1'b0;
         r_ce        <= 1'b0;
         r_iv        <= IV_NONE;
         r_req_ready <= 1'b1;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_opa       <= req_opa;
                  r_opb_lat   <= req_opb;
                  r_cmd       <= req_cmd;
                  r_mode      <= req_mode;
                  r_cin       <= req_cin;
                  r_ce        <= 1'b1;
                  r_req_ready <= 1'b0;
                  if (req_split) begin
                     r_state <= BEAT_A;
                     r_iv    <= IV_A;
                     r_opb   <= '0;
                  end else begin
                     r_state <= ISSUE;
                     r_iv    <= IV_AB;
                     r_opb   <= req_opb;
                  end
               end
            end
            ISSUE, BEAT_B: begin
               r_state <= WAIT;
               r_iv    <= IV_NONE;
               r_cnt   <= CNT_INIT;
            end
            BEAT_A: begin
               r_state <= BEAT_B;
               r_iv    <= IV_B;
               r_opb   <= r_opb_lat;
            end
            WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= RESP;
                  r_ce    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_state     <= IDLE;
                  r_req_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_ce        <= 1'b0;
               r_iv        <= IV_NONE;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   // Result is taken on the last WAIT cycle, RES_LAT edges after the final beat.
   assign w_cap = (r_state == WAIT) && (r_cnt == '0);

   always_comb begin
      w_flags            = '0;
      w_flags[FLG_OFLOW] = oflow;
      w_flags[FLG_COUT]  = cout;
      w_flags[FLG_G]     = g;
      w_flags[FLG_L]     = l;
      w_flags[FLG_E]     = e;
   end

   alu_rsp_buf #(
      .RES_W (WIDTH + 1)
   ) u_rsp_buf (
      .clk     (clk),
      .rst     (rst),
      .i_cap   (w_cap),
      .i_res   (res),
      .i_flags (w_flags),
      .i_err   (err),
      .i_ready (rsp_ready),
      .o_valid (rsp_valid),
      .o_res   (rsp_res),
      .o_flags (rsp_flags),
      .o_err   (rsp_err)
   );

   assign req_ready = r_req_ready;
   assign opa       = r_opa;
   assign opb       = r_opb;
   assign cmd       = r_cmd;
   assign mode      = r_mode;
   assign cin       = r_cin;
   assign ce        = r_ce;
   assign inp_valid = r_iv;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: two instances (RES_LAT 1 and 3), each driving a
// behavioural ALU, exercised by directed steps followed by random requests.
module tb_alu_op_issuer;
   import alu_issuer_pkg::*;

   typedef struct packed {
      logic [8:0] res;
      logic       oflow;
      logic       cout;
      logic       g;
      logic       l;
      logic       e;
      logic       err;
   } alu_out_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       sel;
   logic       req_valid;
   logic [7:0] req_opa, req_opb;
   logic [3:0] req_cmd;
   logic       req_mode, req_cin, req_split;
   logic       rsp_ready;

   logic       rv1, rv3;
   logic       rr1, rr3;
   logic [7:0] opa1, opb1, opa3, opb3;
   logic [3:0] cmd1, cmd3;
   logic       mode1, mode3, cin1, cin3, ce1, ce3;
   logic [1:0] iv1, iv3;
   logic       vld1, vld3, err1, err3;
   logic [8:0] res1, res3;
   logic [4:0] flg1, flg3;

   alu_out_t   p1;
   alu_out_t   p3 [3];
   alu_out_t   nx1, nx3;
   logic [7:0] a1, a3;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   assign rv1 = req_valid & ~sel;
   assign rv3 = req_valid & sel;

   alu_op_issuer #(.WIDTH(8), .CMD_WIDTH(4), .RES_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1),
      .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd), .req_mode(req_mode),
      .req_cin(req_cin), .req_split(req_split),
      .opa(opa1), .opb(opb1), .cmd(cmd1), .mode(mode1), .cin(cin1), .ce(ce1), .inp_valid(iv1),
      .res(p1.res), .oflow(p1.oflow), .cout(p1.cout), .g(p1.g), .l(p1.l), .e(p1.e), .err(p1.err),
      .rsp_valid(vld1), .rsp_ready(rsp_ready), .rsp_res(res1), .rsp_flags(flg1), .rsp_err(err1)
   );

   alu_op_issuer #(.WIDTH(8), .CMD_WIDTH(4), .RES_LAT(3)) u_lat3 (
      .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rr3),
      .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd), .req_mode(req_mode),
      .req_cin(req_cin), .req_split(req_split),
      .opa(opa3), .opb(opb3), .cmd(cmd3), .mode(mode3), .cin(cin3), .ce(ce3), .inp_valid(iv3),
      .res(p3[2].res), .oflow(p3[2].oflow), .cout(p3[2].cout), .g(p3[2].g), .l(p3[2].l),
      .e(p3[2].e), .err(p3[2].err),
      .rsp_valid(vld3), .rsp_ready(rsp_ready), .rsp_res(res3), .rsp_flags(flg3), .rsp_err(err3)
   );

   // Behavioural ALU: arithmetic (mode=1) add/sub with and without carry, compare;
   // logical (mode=0) and/nand/or/xor; anything else reports err.
   function automatic alu_out_t alu_fn(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] c, input logic m, input logic ci);
      alu_out_t o;
      o = '0;
      if (m) begin
         case (c)
            4'd0: begin o.res = 9'(a) + 9'(b);          o.cout  = o.res[8]; end
            4'd1: begin o.res = 9'(a) - 9'(b);          o.oflow = (a < b); end
            4'd2: begin o.res = 9'(a) + 9'(b) + 9'(ci); o.cout  = o.res[8]; end
            4'd3: begin o.res = 9'(a) - 9'(b) - 9'(ci); o.oflow = (9'(a) < 9'(b) + 9'(ci)); end
            4'd8: begin o.g = (a > b); o.l = (a < b); o.e = (a == b); end
            default: o.err = 1'b1;
         endcase
      end else begin
         case (c)
            4'd0: o.res = {1'b0, a & b};
            4'd1: o.res = {1'b0, ~(a & b)};
            4'd2: o.res = {1'b0, a | b};
            4'd3: o.res = {1'b0, a ^ b};
            default: o.err = 1'b1;
         endcase
      end
      return o;
   endfunction

   // The ALU evaluates on the final operand beat; its outputs appear exactly
   // RES_LAT cycles later and are zero in every other cycle.
   assign nx1 = (ce1 && iv1 == 2'b11) ? alu_fn(opa1, opb1, cmd1, mode1, cin1) :
                (ce1 && iv1 == 2'b10) ? alu_fn(a1, opb1, cmd1, mode1, cin1) : '0;
   assign nx3 = (ce3 && iv3 == 2'b11) ? alu_fn(opa3, opb3, cmd3, mode3, cin3) :
                (ce3 && iv3 == 2'b10) ? alu_fn(a3, opb3, cmd3, mode3, cin3) : '0;

   always @(posedge clk) begin
      if (ce1 && iv1 == 2'b01) a1 <= opa1;
      if (ce3 && iv3 == 2'b01) a3 <= opa3;
      p1    <= nx1;
      p3[0] <= nx3;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   logic       o_ready, o_ce, o_mode, o_cin, o_vld, o_err;
   logic [7:0] o_opa, o_opb;
   logic [3:0] o_cmd;
   logic [1:0] o_iv;
   logic [8:0] o_res;
   logic [4:0] o_flg;

   assign o_ready = sel ? rr3   : rr1;
   assign o_ce    = sel ? ce3   : ce1;
   assign o_mode  = sel ? mode3 : mode1;
   assign o_cin   = sel ? cin3  : cin1;
   assign o_opa   = sel ? opa3  : opa1;
   assign o_opb   = sel ? opb3  : opb1;
   assign o_cmd   = sel ? cmd3  : cmd1;
   assign o_iv    = sel ? iv3   : iv1;
   assign o_vld   = sel ? vld3  : vld1;
   assign o_res   = sel ? res3  : res1;
   assign o_flg   = sel ? flg3  : flg1;
   assign o_err   = sel ? err3  : err1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                          input logic m, input logic ci, input logic sp,
                          input int lat, input int hold, input bit early);
      alu_out_t ex;
      int       cyc;
      ex = alu_fn(a, b, c, m, ci);
      rsp_ready = (hold == 0);
      chk("idle_ready", o_ready, 1);
      req_valid = 1'b1;
      req_opa   = a;
      req_opb   = b;
      req_cmd   = c;
      req_mode  = m;
      req_cin   = ci;
      req_split = sp;
      tick();
      req_valid = 1'b0;
      chk("c1_ce", o_ce, 1);
      chk("c1_ready", o_ready, 0);
      chk("c1_opa", o_opa, a);
      chk("c1_cmd", {o_cmd, o_mode, o_cin}, {c, m, ci});
      if (!sp) begin
         chk("c1_iv_ab", o_iv, 2'b11);
         chk("c1_opb", o_opb, b);
         cyc = 1;
      end else begin
         chk("c1_iv_a", o_iv, 2'b01);
         chk("c1_opb_zero", o_opb, 0);
         tick();
         chk("c2_iv_b", o_iv, 2'b10);
         chk("c2_opb", o_opb, b);
         chk("c2_opa_held", o_opa, a);
         cyc = 2;
      end
      while (!o_vld && cyc < 60) begin
         tick();
         cyc++;
         if (!o_vld) chk("wait_ce", o_ce, 1);
      end
      chk("rsp_cycle", cyc, lat + 2 + sp);
      chk("rsp_res", o_res, ex.res);
      chk("rsp_flags", o_flg, {ex.oflow, ex.cout, ex.g, ex.l, ex.e});
      chk("rsp_err", o_err, ex.err);
      chk("resp_ce", o_ce, 0);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk("bp_valid", o_vld, 1);
         chk("bp_res", o_res, ex.res);
         chk("bp_flags", o_flg, {ex.oflow, ex.cout, ex.g, ex.l, ex.e});
         chk("bp_ready", o_ready, 0);
         chk("bp_ce", o_ce, 0);
      end
      rsp_ready = 1'b1;
      if (early) req_valid = 1'b1;
      tick();
      chk("rsp_done", o_vld, 0);
      chk("back_idle", o_ready, 1);
      if (early) chk("no_early_accept", o_ce, 0);
   endtask

   logic [3:0] cmd_tbl [6];
   alu_out_t   ex_d;
   logic       seen;

   initial begin
      cmd_tbl   = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd13};
      rst       = 1'b0;
      sel       = 1'b0;
      req_valid = 1'b1;
      req_opa   = 8'h3C;
      req_opb   = 8'h44;
      req_cmd   = 4'd0;
      req_mode  = 1'b1;
      req_cin   = 1'b0;
      req_split = 1'b0;
      rsp_ready = 1'b1;

      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_ready", o_ready, 1);
         chk("rst_ce", o_ce, 0);
         chk("rst_iv", o_iv, 2'b00);
         chk("rst_rsp_valid", o_vld, 0);
         chk("rst_opa", {o_opa, o_opb}, 16'h0000);
         chk("rst_rsp_res", {o_res, o_flg, o_err}, 15'h0000);
      end
      chk("rst_lat3_ready", rr3, 1);
      chk("rst_lat3_ce", ce3, 0);
      rst       = 1'b1;
      req_valid = 1'b0;

      // Non-split ADD, then split ADD with carry out.
      run_txn(8'h0F, 8'h01, 4'd0, 1'b1, 1'b0, 1'b0, 1, 0, 0);
      chk("add_cout_clear", o_flg[FLG_COUT], 0);
      run_txn(8'hFF, 8'h01, 4'd0, 1'b1, 1'b0, 1'b1, 1, 0, 0);
      ex_d = alu_fn(8'hFF, 8'h01, 4'd0, 1'b1, 1'b0);
      chk("split_res_const", ex_d.res, 9'h100);
      chk("split_cout_set", o_flg[FLG_COUT], 1);

      // Backpressure for five cycles, then a request offered during RESP.
      run_txn(8'h80, 8'h7F, 4'd1, 1'b1, 1'b0, 1'b0, 1, 5, 1);
      run_txn(8'hA5, 8'h5A, 4'd3, 1'b0, 1'b0, 1'b0, 1, 0, 0);

      // Reset asserted during WAIT drops the transaction.
      req_valid = 1'b1;
      req_opa   = 8'h11;
      req_opb   = 8'h22;
      req_split = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mid_rst_ce", o_ce, 0);
      chk("mid_rst_iv", o_iv, 2'b00);
      chk("mid_rst_ready", o_ready, 1);
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         seen = seen | o_vld;
      end
      chk("mid_rst_no_rsp", seen, 0);
      run_txn(8'h33, 8'h44, 4'd2, 1'b1, 1'b1, 1'b0, 1, 0, 0);

      // RES_LAT=3 instance: compare equal operands, then a split subtract.
      sel = 1'b1;
      run_txn(8'd5, 8'd5, 4'd8, 1'b1, 1'b0, 1'b0, 3, 0, 0);
      chk("lat3_eq_flag", o_flg[FLG_E], 1);
      run_txn(8'h10, 8'h20, 4'd1, 1'b1, 1'b0, 1'b1, 3, 2, 0);

      for (int k = 0; k < 24; k++) begin
         sel = 1'($urandom_range(0, 1));
         run_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 cmd_tbl[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 sel ? 3 : 1, $urandom_range(0, 2), 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
